// File: rtl/dm_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
// The optional statistics counters are enabled by defining DM_ARB_STATS_EN.
package dm_arb_pkg;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_MAX_WAIT = 4;

    // Starvation counter width; MAX_WAIT is legal from 1 to 15.
    localparam int WAIT_W = 4;

    // Statistics counter widths (used only when DM_ARB_STATS_EN is defined).
    localparam int CONFLICT_CNT_W = 16;
    localparam int FORCE_CNT_W    = 8;

    typedef enum logic {
        NORMAL,
        FORCE
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_PIPE,
        OWN_LD
    } owner_e;

endpackage

// File: rtl/dm_arb_starve_ctr.sv
// Loader starvation guard: counts consecutive lost arbitration cycles and
// raises force_slot for exactly one loader beat once MAX_WAIT is reached.
// With DM_ARB_STATS_EN defined it also counts NORMAL->FORCE transitions.
module dm_arb_starve_ctr
    import dm_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clk,
    input  logic reset,
    input  logic ld_req,
    input  logic ld_gnt,
    output logic force_slot
`ifdef DM_ARB_STATS_EN
    ,
    output logic [FORCE_CNT_W-1:0] force_cnt
`endif
);

    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAX_WAIT - 1);

    arb_state_e        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              lost;
    logic              enter_force;

    // A lost cycle is a loader request that the arbiter did not take.
    assign lost        = ld_req & ~ld_gnt;
    assign enter_force = (state == NORMAL) && lost && (wait_cnt == LAST_WAIT);
    assign force_slot  = (state == FORCE);

    // Starvation counter and NORMAL/FORCE state machine.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    // NOTE: only control state is reset; datapath values need no reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= NORMAL;
            wait_cnt <= '0;
        end else begin
            if (!ld_req || ld_gnt) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            case (state)
                NORMAL:  if (enter_force)        state <= FORCE;
                FORCE:   if (ld_gnt || !ld_req)  state <= NORMAL;
                default:                         state <= NORMAL;
            endcase
        end
    end

`ifdef DM_ARB_STATS_EN
    // Saturating count of starvation episodes that forced a loader slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            force_cnt <= '0;
        end else if (enter_force && (force_cnt != '1)) begin
            force_cnt <= force_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/dm_port_arbiter.sv
// Arbitrates the single-port data memory between the pipeline DM stage
// (priority) and the loader/debug port, with a starvation guard that forces
// one loader beat and stalls the pipeline. Read data is returned one cycle
// after the grant to whichever requester owned the read.
// Optional: define DM_ARB_STATS_EN to add the conflict_cnt/force_cnt ports.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_en,
    input  logic              pipe_rw,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic              pipe_stall,
    output logic [DATA_W-1:0] pipe_rdata,
    output logic              pipe_rvalid,
    input  logic              ld_req,
    input  logic              ld_rw,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
`ifdef DM_ARB_STATS_EN
    ,
    output logic [CONFLICT_CNT_W-1:0] conflict_cnt,
    output logic [FORCE_CNT_W-1:0]    force_cnt
`endif
);

    owner_e owner;
    owner_e rd_tag;
    logic   rd_flag;
    logic   force_slot;

    dm_arb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_ctr (
        .clk        (clk),
        .reset      (reset),
        .ld_req     (ld_req),
        .ld_gnt     (ld_gnt),
        .force_slot (force_slot)
`ifdef DM_ARB_STATS_EN
        ,
        .force_cnt  (force_cnt)
`endif
    );

    // Ownership decision: pipeline first unless a forced loader slot is due.
    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        owner      = OWN_NONE;
        ld_gnt     = 1'b0;
        pipe_stall = 1'b0;
        if (reset) begin
            if (ld_req && (force_slot || !pipe_en)) begin
                owner      = OWN_LD;
                ld_gnt     = 1'b1;
                pipe_stall = pipe_en;
            end else if (pipe_en) begin
                owner = OWN_PIPE;
            end
        end
    end

    // Memory port mux; with no owner the address/data follow the pipeline.
    always_comb begin
        mem_en   = (owner != OWN_NONE);
        mem_we   = 1'b0;
        mem_addr = pipe_addr;
        mem_din  = pipe_wdata;
        case (owner)
            OWN_PIPE: mem_we = pipe_rw;
            OWN_LD: begin
                mem_we   = ld_rw;
                mem_addr = ld_addr;
                mem_din  = ld_wdata;
            end
            default: ;
        endcase
    end

    // Remember who issued a read so the returning data reaches its owner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_flag <= 1'b0;
            rd_tag  <= OWN_NONE;
        end else begin
            rd_flag <= mem_en & ~mem_we;
            rd_tag  <= owner;
        end
    end

    assign pipe_rvalid = rd_flag && (rd_tag == OWN_PIPE);
    assign ld_rvalid   = rd_flag && (rd_tag == OWN_LD);
    assign pipe_rdata  = mem_dout;
    assign ld_rdata    = mem_dout;

`ifdef DM_ARB_STATS_EN
    // Saturating count of cycles where both requesters asked together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_cnt <= '0;
        end else if (pipe_en && ld_req && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: a behavioural memory on the
// memory pins, a reference arbitration model and directed plus random tests.
module tb_dm_port_arbiter;

    localparam int MAX_WAIT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       pipe_en, pipe_rw, pipe_stall, pipe_rvalid;
    logic [7:0] pipe_addr, pipe_wdata, pipe_rdata;
    logic       ld_req, ld_rw, ld_gnt, ld_rvalid;
    logic [7:0] ld_addr, ld_wdata, ld_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_din, mem_dout;
`ifdef DM_ARB_STATS_EN
    logic [15:0] conflict_cnt;
    logic [7:0]  force_cnt;
`endif

    always #5 clk = ~clk;

    dm_port_arbiter #(
        .ADDR_W   (8),
        .DATA_W   (8),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pipe_en      (pipe_en),
        .pipe_rw      (pipe_rw),
        .pipe_addr    (pipe_addr),
        .pipe_wdata   (pipe_wdata),
        .pipe_stall   (pipe_stall),
        .pipe_rdata   (pipe_rdata),
        .pipe_rvalid  (pipe_rvalid),
        .ld_req       (ld_req),
        .ld_rw        (ld_rw),
        .ld_addr      (ld_addr),
        .ld_wdata     (ld_wdata),
        .ld_gnt       (ld_gnt),
        .ld_rdata     (ld_rdata),
        .ld_rvalid    (ld_rvalid),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout)
`ifdef DM_ARB_STATS_EN
        ,
        .conflict_cnt (conflict_cnt),
        .force_cnt    (force_cnt)
`endif
    );

    // Single-port synchronous RAM with one-cycle read latency (read-first).
    logic [7:0] sram [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_din;
            mem_dout <= sram[mem_addr];
        end
    end

    int total = 0;
    int bad   = 0;

    // Reference model: memory image plus starvation bookkeeping.
    logic [7:0] ref_mem [0:255];
    int         losses;
    bit         forced;
    int         conflicts;
    int         forces;

    // Values seen by the most recent step, for directed checks.
    logic       obs_gnt, obs_stall, obs_en, obs_we, obs_prv, obs_lrv;
    logic [7:0] obs_addr, obs_din, obs_prdata, obs_lrdata;

    task automatic model_reset();
        losses    = 0;
        forced    = 1'b0;
        conflicts = 0;
        forces    = 0;
    endtask

    task automatic drive_idle();
        pipe_en = 0; pipe_rw = 0; pipe_addr = 0; pipe_wdata = 0;
        ld_req  = 0; ld_rw   = 0; ld_addr   = 0; ld_wdata   = 0;
    endtask

    // One clock cycle starting at a negedge: drive, check grant/mux against
    // the model, cross the posedge, check read return, end at next negedge.
    task automatic step(input logic pe, input logic prw, input logic [7:0] pa, input logic [7:0] pw,
                        input logic lr, input logic lrw, input logic [7:0] la, input logic [7:0] lw);
        bit         e_gnt, e_stall, e_pown, e_en, e_we, e_prv, e_lrv;
        logic [7:0] e_addr, e_din, e_rd;
        pipe_en = pe; pipe_rw = prw; pipe_addr = pa; pipe_wdata = pw;
        ld_req  = lr; ld_rw   = lrw; ld_addr   = la; ld_wdata   = lw;
        #1;
        e_gnt   = lr && (forced || !pe);
        e_stall = pe && e_gnt;
        e_pown  = pe && !e_gnt;
        e_en    = e_gnt || e_pown;
        e_we    = e_gnt ? lrw : (e_pown ? prw : 1'b0);
        e_addr  = e_gnt ? la : pa;
        e_din   = e_gnt ? lw : pw;
        total++; if (ld_gnt !== e_gnt) begin bad++; $display("FAIL ld_gnt t=%0t got=%b exp=%b", $time, ld_gnt, e_gnt); end
        total++; if (pipe_stall !== e_stall) begin bad++; $display("FAIL pipe_stall t=%0t got=%b exp=%b", $time, pipe_stall, e_stall); end
        total++; if (mem_en !== e_en) begin bad++; $display("FAIL mem_en t=%0t got=%b exp=%b", $time, mem_en, e_en); end
        total++; if (mem_we !== e_we) begin bad++; $display("FAIL mem_we t=%0t got=%b exp=%b", $time, mem_we, e_we); end
        total++; if (mem_addr !== e_addr) begin bad++; $display("FAIL mem_addr t=%0t got=%h exp=%h", $time, mem_addr, e_addr); end
        total++; if (mem_din !== e_din) begin bad++; $display("FAIL mem_din t=%0t got=%h exp=%h", $time, mem_din, e_din); end
        obs_gnt = ld_gnt; obs_stall = pipe_stall; obs_en = mem_en; obs_we = mem_we;
        obs_addr = mem_addr; obs_din = mem_din;

        e_prv = e_pown && !prw;
        e_lrv = e_gnt && !lrw;
        e_rd  = e_gnt ? ref_mem[la] : ref_mem[pa];
        if (e_gnt && lrw) ref_mem[la] = lw;
        else if (e_pown && prw) ref_mem[pa] = pw;
        if (pe && lr) conflicts++;
        if (lr && !e_gnt) begin
            losses++;
            if (losses == MAX_WAIT) begin
                forced = 1'b1;
                forces++;
            end
        end else begin
            losses = 0;
            forced = 1'b0;
        end

        @(posedge clk); #1;
        total++; if (pipe_rvalid !== e_prv) begin bad++; $display("FAIL pipe_rvalid t=%0t got=%b exp=%b", $time, pipe_rvalid, e_prv); end
        total++; if (ld_rvalid !== e_lrv) begin bad++; $display("FAIL ld_rvalid t=%0t got=%b exp=%b", $time, ld_rvalid, e_lrv); end
        if (e_prv) begin
            total++; if (pipe_rdata !== e_rd) begin bad++; $display("FAIL pipe_rdata t=%0t got=%h exp=%h", $time, pipe_rdata, e_rd); end
        end
        if (e_lrv) begin
            total++; if (ld_rdata !== e_rd) begin bad++; $display("FAIL ld_rdata t=%0t got=%h exp=%h", $time, ld_rdata, e_rd); end
        end
        obs_prv = pipe_rvalid; obs_lrv = ld_rvalid; obs_prdata = pipe_rdata; obs_lrdata = ld_rdata;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pipe_en = 1; pipe_rw = 0; pipe_addr = 8'h10; pipe_wdata = 0;
        ld_req  = 1; ld_rw   = 0; ld_addr   = 8'h11; ld_wdata   = 0;
        @(negedge clk); #1;
        total++; if (ld_gnt !== 1'b0) begin bad++; $display("FAIL reset_ld_gnt got=%b exp=0", ld_gnt); end
        total++; if (pipe_stall !== 1'b0) begin bad++; $display("FAIL reset_pipe_stall got=%b exp=0", pipe_stall); end
        total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
        @(posedge clk); #1;
        total++; if (pipe_rvalid !== 1'b0 || ld_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b%b exp=00", pipe_rvalid, ld_rvalid); end
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        model_reset();
    endtask

    // Loader fills addresses 0x00-0x0F, plus 0x10 with 0x5A.
    task automatic test_preload();
        logic [7:0] v;
        for (int i = 0; i < 16; i++) begin
            v = (i == 1) ? 8'h11 : (i == 2) ? 8'h22 : 8'($urandom_range(0, 255));
            step(0, 0, 8'h00, 8'h00, 1, 1, 8'(i), v);
        end
        step(0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'h5A);
    endtask

    task automatic test_pipe_read();
        step(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        total++; if (obs_en !== 1'b1) begin bad++; $display("FAIL pipe_read_en got=%b exp=1", obs_en); end
        total++; if (obs_prv !== 1'b1 || obs_prdata !== 8'h5A) begin bad++; $display("FAIL pipe_read_data got=%b/%h exp=1/5a", obs_prv, obs_prdata); end
        total++; if (obs_lrv !== 1'b0) begin bad++; $display("FAIL pipe_read_ldrv got=%b exp=0", obs_lrv); end
    endtask

    task automatic test_loader_write();
        step(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'hC3);
        total++; if ({obs_gnt, obs_we, obs_addr, obs_din} !== {1'b1, 1'b1, 8'h20, 8'hC3}) begin
            bad++; $display("FAIL ld_write got=%b/%b/%h/%h exp=1/1/20/c3", obs_gnt, obs_we, obs_addr, obs_din);
        end
        total++; if (obs_prv !== 1'b0 && obs_lrv !== 1'b0) begin bad++; $display("FAIL ld_write_rvalid got=%b%b exp=00", obs_prv, obs_lrv); end
        step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        step(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00);
        total++; if (obs_prdata !== 8'hC3) begin bad++; $display("FAIL ld_write_readback got=%h exp=c3", obs_prdata); end
    endtask

    task automatic test_starvation();
        logic exp_g;
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 8'h03, 8'h00, 1, 0, 8'h04, 8'h00);
            exp_g = (i == 4) || (i == 9);
            total++; if (obs_gnt !== exp_g || obs_stall !== exp_g) begin
                bad++; $display("FAIL starve_cycle%0d got=%b/%b exp=%b/%b", i, obs_gnt, obs_stall, exp_g, exp_g);
            end
        end
        step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic test_back_to_back();
        step(1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00);
        total++; if (obs_prv !== 1'b1 || obs_lrv !== 1'b0 || obs_prdata !== 8'h11) begin
            bad++; $display("FAIL b2b_pipe got=%b%b/%h exp=10/11", obs_prv, obs_lrv, obs_prdata);
        end
        step(0, 0, 8'h00, 8'h00, 1, 0, 8'h02, 8'h00);
        total++; if (obs_prv !== 1'b0 || obs_lrv !== 1'b1 || obs_lrdata !== 8'h22) begin
            bad++; $display("FAIL b2b_ld got=%b%b/%h exp=01/22", obs_prv, obs_lrv, obs_lrdata);
        end
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) step(1, 0, 8'(i), 8'h00, 0, 0, 8'h00, 8'h00);
            else            step(0, 0, 8'h00, 8'h00, 1, 0, 8'(i), 8'h00);
            total++; if (obs_prv && obs_lrv) begin bad++; $display("FAIL b2b_both got=11 exp=one"); end
        end
    endtask

    task automatic test_reset_mid_wait();
        step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) step(1, 0, 8'h05, 8'h00, 1, 0, 8'h06, 8'h00);
        // Fourth contested cycle would be the last loss; reset it mid-cycle.
        pipe_en = 1; pipe_rw = 0; pipe_addr = 8'h07; ld_req = 1; ld_rw = 0; ld_addr = 8'h08;
        #1;
        reset = 1'b0;
        #1;
        total++; if ({ld_gnt, pipe_stall, mem_en} !== 3'b000) begin bad++; $display("FAIL rst_mid_outs got=%b%b%b exp=000", ld_gnt, pipe_stall, mem_en); end
        total++; if ({pipe_rvalid, ld_rvalid} !== 2'b00) begin bad++; $display("FAIL rst_mid_rvalid_now got=%b%b exp=00", pipe_rvalid, ld_rvalid); end
        @(posedge clk); #1;
        total++; if ({pipe_rvalid, ld_rvalid} !== 2'b00) begin bad++; $display("FAIL rst_mid_rvalid_after got=%b%b exp=00", pipe_rvalid, ld_rvalid); end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 8'h05, 8'h00, 1, 0, 8'h06, 8'h00);
            total++; if (obs_gnt !== (i == 4)) begin bad++; $display("FAIL rst_mid_fresh%0d got=%b exp=%b", i, obs_gnt, (i == 4)); end
        end
        step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 60, $urandom_range(0, 3) == 0, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                 $urandom_range(0, 99) < 55, $urandom_range(0, 2) == 0, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        end
    endtask

`ifdef DM_ARB_STATS_EN
    task automatic test_stats();
        total++; if (conflict_cnt !== 16'(conflicts)) begin bad++; $display("FAIL stats_conflict_rand got=%0d exp=%0d", conflict_cnt, conflicts); end
        total++; if (force_cnt !== 8'(forces)) begin bad++; $display("FAIL stats_force_rand got=%0d exp=%0d", force_cnt, forces); end
        reset = 1'b0;
        #1;
        reset = 1'b1;
        model_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 5; i++) step(1, 0, 8'h09, 8'h00, 1, 0, 8'h0A, 8'h00);
            step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        end
        total++; if (conflict_cnt !== 16'd10) begin bad++; $display("FAIL stats_conflict got=%0d exp=10", conflict_cnt); end
        total++; if (force_cnt !== 8'd2) begin bad++; $display("FAIL stats_force got=%0d exp=2", force_cnt); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        model_reset();
        test_reset();
        test_preload();
        test_pipe_read();
        test_loader_write();
        test_starvation();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
`ifdef DM_ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single-port 8-bit data memory between two requesters:
  - the pipeline's DM stage (primary);
  - a loader/debug port (secondary), used for program/data preload and inspection.
- Drives the memory's ena/wea/addra/dina directly and routes douta back to the owner of each read, one cycle later.
- Fixed priority to the pipeline, with a starvation guard that forces a loader slot and stalls the pipeline.

Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- MAX_WAIT, 4, consecutive lost arbitration cycles before the loader is forced a slot (legal 1..15)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (reset==0 clears)
- pipe_en  in  1  pipeline access request this cycle
- pipe_rw  in  1  1=write, 0=read
- pipe_addr  in  ADDR_W  pipeline address
- pipe_wdata  in  DATA_W  pipeline write data
- pipe_stall  out  1  pipeline access not taken this cycle; hold request
- pipe_rdata  out  DATA_W  read data (valid with pipe_rvalid)
- pipe_rvalid  out  1  pipeline read data valid
- ld_req  in  1  loader access request
- ld_rw  in  1  1=write, 0=read
- ld_addr  in  ADDR_W  loader address
- ld_wdata  in  DATA_W  loader write data
- ld_gnt  out  1  loader access taken this cycle
- ld_rdata  out  DATA_W  read data (valid with ld_rvalid)
- ld_rvalid  out  1  loader read data valid
- mem_en  out  1  to memory ena
- mem_we  out  1  to memory wea
- mem_addr  out  ADDR_W  to memory addra
- mem_din  out  DATA_W  to memory dina
- mem_dout  in  DATA_W  from memory douta (1-cycle read latency)

Behaviour:
- Grant and stall are combinational in the request cycle. The memory samples on the next posedge of clk.
- FSM states: NORMAL, FORCE.
- NORMAL:
  - pipe_en=1: pipeline owns the memory; ld_gnt=0; pipe_stall=0.
  - Otherwise, ld_req=1 gives ld_gnt=1 and the loader owns the memory.
- FORCE:
  - ld_req=1: ld_gnt=1, loader owns the memory, pipe_stall=pipe_en.
  - ld_req=0: behaves as NORMAL.
- Memory outputs:
  - mem_en = 1 when there is an owner.
  - mem_we/addr/din are muxed from the owner.
  - No owner: mem_en=0, mem_we=0; addr/din hold the pipeline values.
- wait_cnt (4 bits):
  - Increments on each cycle with ld_req=1 and ld_gnt=0.
  - Clears on ld_gnt=1 or ld_req=0.
- Transitions:
  - NORMAL→FORCE when a lost cycle occurs with wait_cnt==MAX_WAIT-1, so after MAX_WAIT consecutive losses the loader is granted on the next cycle.
  - FORCE→NORMAL after one loader grant, or when ld_req=0.
  - Exactly one forced beat per starvation episode.
- Read return:
  - Owner tag and read flag are registered at the grant edge.
  - pipe_rvalid/ld_rvalid pulse for exactly one cycle, one cycle after a granted read (rw=0).
  - pipe_rdata=ld_rdata=mem_dout.
  - No rvalid follows a write.
- Back-to-back reads from alternating owners are legal every cycle; tags pipeline correctly.
- Reset (async, reset==0):
  - state=NORMAL, wait_cnt=0, rvalids=0.
  - While reset is low, mem_en=0, ld_gnt=0, pipe_stall=0.
  - Reset mid-wait discards the starvation count.
  - A read issued in the cycle before reset asserts produces no rvalid.
- Simultaneous pipe_en and ld_req in FORCE: the loader wins; the pipeline stalls exactly one cycle.

Optional Feature:
- Macro: DM_ARB_STATS_EN.
- Defined:
  - Adds output conflict_cnt (16 bits): a saturating count of cycles with pipe_en=1 and ld_req=1 together.
  - Adds output force_cnt (8 bits): a saturating count of NORMAL→FORCE transitions.
  - Both clear on reset.
- Undefined: neither port nor counter exists; the arbitration behaviour is identical.

Decomposition:
- Package dm_arb_pkg:
  - ADDR_W/DATA_W defaults;
  - state enum {NORMAL, FORCE};
  - owner enum {OWN_NONE, OWN_PIPE, OWN_LD};
  - stats widths.
- Sub-module dm_arb_starve_ctr: holds wait_cnt and the FSM, and outputs force_slot.
- The top level handles muxing and the read-return tag.

Test Plan:
- Pipeline read only: pipe_en=1, rw=0, addr=0x10, memory holds 0x5A → mem_en=1 same cycle; pipe_rvalid=1 with pipe_rdata=0x5A next cycle; ld_rvalid=0.
- Loader write in an idle cycle: ld_req=1, rw=1, addr=0x20, wdata=0xC3 → ld_gnt=1, mem_we=1, mem_addr=0x20, mem_din=0xC3; a later pipeline read of 0x20 returns 0xC3.
- Starvation with MAX_WAIT=4: pipe_en and ld_req held high → ld_gnt=0 for cycles 0-3; cycle 4 has ld_gnt=1 and pipe_stall=1; cycle 5 has pipe_stall=0 and ld_gnt=0; wait_cnt restarts.
- Interleaved reads: pipeline read 0x01 (data 0x11), loader read 0x02 (data 0x22) on consecutive cycles → pipe_rvalid with 0x11, then ld_rvalid with 0x22; never both high together.
- Async reset asserted at wait_cnt=3 with a read in flight → outputs drop immediately; no rvalid; after release a fresh 4-cycle wait is needed before forcing.
- DM_ARB_STATS_EN defined, the starvation scenario run twice → conflict_cnt=10, force_cnt=2.
